// File: rtl/result_streamer_pkg.sv
// Shared constants and types for the result streamer and its ping-pong buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_streamer_pkg;

  // Matrix dimension of the multiplier this drain stage normally sits behind.
  localparam int unsigned N_DEFAULT = 4;

  // Width of one result element.
  localparam int unsigned ELEM_W = 32;

  // Row/column index type for the default dimension.
  localparam int unsigned IDX_W = $clog2(N_DEFAULT);
  typedef logic [IDX_W-1:0] idx_t;

  // Elements per matrix, i.e. beats per drained slot.
  localparam int unsigned NUM_ELEM = N_DEFAULT * N_DEFAULT;

endpackage

// File: rtl/result_pingpong_buf.sv
// Two-slot matrix store with full bits and write/read slot pointers.
// Latency: a write is visible on o_full/o_rd_mat the cycle after i_wr.
// Backpressure: none here; the parent decides when i_wr/i_free may fire.
//
// Ports:
//   i_clk, i_arst_n  clock, async active-low reset
//   i_wr, i_wr_mat   write strobe and matrix; writes slot wrSel, sets its full bit, toggles wrSel
//   i_free           clears full[rdSel] and toggles rdSel
//   o_full           full bit per slot
//   o_rd_sel         slot currently being drained
//   o_rd_mat         contents of slot rdSel
module result_pingpong_buf
  import result_streamer_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic                              i_wr,
  input  logic [N-1:0][N-1:0][ELEM_W-1:0]   i_wr_mat,
  input  logic                              i_free,
  output logic [1:0]                        o_full,
  output logic                              o_rd_sel,
  output logic [N-1:0][N-1:0][ELEM_W-1:0]   o_rd_mat
);

  logic [1:0][N-1:0][N-1:0][ELEM_W-1:0] slot_q, slot_d;
  logic [1:0]                           full_q, full_d;
  logic                                 wr_sel_q, wr_sel_d;
  logic                                 rd_sel_q, rd_sel_d;

  always_comb begin
    slot_d   = slot_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (i_free) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    // Write is applied after free: when both slots are full and the last beat
    // of rdSel retires in the same cycle, wrSel == rdSel and the slot must end
    // up full again with the new matrix.
    if (i_wr) begin
      slot_d[wr_sel_q] = i_wr_mat;
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      slot_q   <= '0;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  assign o_full   = full_q;
  assign o_rd_sel = rd_sel_q;
  assign o_rd_mat = slot_q[rd_sel_q];

endmodule

// File: rtl/result_streamer.sv
// Captures NxN result matrices into a ping-pong buffer and streams them row-major.
// Latency: first element valid the cycle after the capture pulse; 1 element/cycle, no bubble between slots.
// Backpressure: valid/ready on the output; a result arriving with both slots full is dropped and flagged sticky.
//
// Ports:
//   i_clk, i_arst_n        clock, async active-low reset
//   i_c, i_validResult     result matrix and its one-cycle valid pulse
//   o_canAccept            at least one slot free (registered full bits only)
//   o_valid, i_ready       output handshake
//   o_data, o_row, o_col   current element and its position
//   o_last                 current element is (N-1,N-1)
//   o_overflow             sticky: a result was dropped since reset
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic [N-1:0][N-1:0][ELEM_W-1:0]   i_c,
  input  logic                              i_validResult,
  output logic                              o_canAccept,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [ELEM_W-1:0]                 o_data,
  output logic [$clog2(N)-1:0]              o_row,
  output logic [$clog2(N)-1:0]              o_col,
  output logic                              o_last,
  output logic                              o_overflow
);

  localparam int unsigned    RW       = $clog2(N);
  localparam logic [RW-1:0]  LAST_IDX = RW'(N - 1);

  logic [1:0]                            full;
  logic                                  rd_sel;
  logic [N-1:0][N-1:0][ELEM_W-1:0]       rd_mat;

  // The element index is kept as a row/column pair so no divider is needed.
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic          ovf_q, ovf_d;

  logic both_full;
  logic valid;
  logic at_last;
  logic fire;
  logic last_fire;
  logic accept;
  logic drop;

  assign both_full = &full;
  assign valid     = full[rd_sel];
  assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign fire      = valid && i_ready;
  assign last_fire = fire && at_last;
  // A full buffer still accepts when the slot being drained retires this cycle.
  assign accept    = i_validResult && (!both_full || last_fire);
  assign drop      = i_validResult && !accept;

  result_pingpong_buf #(.N(N)) u_buf (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_wr     (accept),
    .i_wr_mat (i_c),
    .i_free   (last_fire),
    .o_full   (full),
    .o_rd_sel (rd_sel),
    .o_rd_mat (rd_mat)
  );

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ovf_d = ovf_q | drop;
    if (fire) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = at_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      row_q <= '0;
      col_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_canAccept = !both_full;
  assign o_valid     = valid;
  assign o_data      = rd_mat[row_q][col_q];
  assign o_row       = row_q;
  assign o_col       = col_q;
  assign o_last      = valid && at_last;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: scoreboard on the output stream plus
// a table of per-cycle status vectors and hand-written corner sequences.
module tb_result_streamer;
  import result_streamer_pkg::*;

  localparam int N = N_DEFAULT;

  typedef logic [N-1:0][N-1:0][ELEM_W-1:0] mat_t;

  typedef struct {
    logic [31:0] data;
    idx_t        row;
    idx_t        col;
    logic        last;
  } exp_t;

  typedef struct {
    logic vld;
    logic rdy;
    int   base;
    logic acc;
    logic e_valid;
    logic e_can;
    logic e_ovf;
  } vec_t;

  logic              clk = 1'b0;
  logic              arst_n;
  mat_t              c_in;
  logic              vld;
  logic              rdy;
  logic              can;
  logic              o_valid;
  logic [ELEM_W-1:0] o_data;
  idx_t              o_row;
  idx_t              o_col;
  logic              o_last;
  logic              ovf;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  int   first_pop = -1;
  int   last_pop = -1;
  logic mon_en = 1'b0;
  exp_t q[$];

  result_streamer #(.N(N)) dut (
    .i_clk         (clk),
    .i_arst_n      (arst_n),
    .i_c           (c_in),
    .i_validResult (vld),
    .o_canAccept   (can),
    .o_valid       (o_valid),
    .i_ready       (rdy),
    .o_data        (o_data),
    .o_row         (o_row),
    .o_col         (o_col),
    .o_last        (o_last),
    .o_overflow    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic mat_t gen(input int base);
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = 32'(base + 16 * r + c);
    return m;
  endfunction

  task automatic push_mat(input int base);
    exp_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.data = 32'(base + 16 * r + c);
        e.row  = idx_t'(r);
        e.col  = idx_t'(c);
        e.last = (r == N - 1) && (c == N - 1);
        q.push_back(e);
      end
  endtask

  // One capture pulse over one clock edge; returns at posedge+1.
  task automatic pulse(input int base, input bit acc);
    c_in = gen(base);
    vld  = 1'b1;
    if (acc) push_mat(base);
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  // Run until the scoreboard is empty; pat=1 drives ready as 1,0,0,1 repeating.
  task automatic drain(input int max_cycles, input bit pat);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      rdy = pat ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    rdy = 1'b1;
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic clr_stats();
    pop_cnt   = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  // Scoreboard: the head entry must be on the outputs whenever o_valid is high;
  // it retires when the consumer is ready.
  always @(negedge clk) begin
    if (mon_en && arst_n && o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", o_data, 32'hDEAD_BEEF);
      end else begin
        chk("data", o_data, q[0].data);
        chk("row", 32'(o_row), 32'(q[0].row));
        chk("col", 32'(o_col), 32'(q[0].col));
        chk("last", 32'(o_last), 32'(q[0].last));
        if (rdy) begin
          void'(q.pop_front());
          pop_cnt++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{vld: 1'b1, rdy: 1'b0, base: 'h100, acc: 1'b1, e_valid: 1'b1, e_can: 1'b1, e_ovf: 1'b0};
    vecs[1] = '{vld: 1'b0, rdy: 1'b0, base: 0,     acc: 1'b0, e_valid: 1'b1, e_can: 1'b1, e_ovf: 1'b0};
    vecs[2] = '{vld: 1'b1, rdy: 1'b0, base: 'h200, acc: 1'b1, e_valid: 1'b1, e_can: 1'b0, e_ovf: 1'b0};
    vecs[3] = '{vld: 1'b1, rdy: 1'b0, base: 'h300, acc: 1'b0, e_valid: 1'b1, e_can: 1'b0, e_ovf: 1'b1};
    vecs[4] = '{vld: 1'b0, rdy: 1'b0, base: 0,     acc: 1'b0, e_valid: 1'b1, e_can: 1'b0, e_ovf: 1'b1};

    arst_n = 1'b0;
    vld    = 1'b0;
    rdy    = 1'b0;
    c_in   = '0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_row", 32'(o_row), 32'd0);
    chk("rst_col", 32'(o_col), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_can", 32'(can), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    mon_en = 1'b1;

    // Single matrix, ready held high.
    rdy = 1'b1;
    clr_stats();
    pulse(0, 1'b1);
    chk("single_latency_valid", 32'(o_valid), 32'd1);
    drain(100, 1'b0);
    chk("single_beats", 32'(pop_cnt), 32'd16);
    chk("single_contig", 32'(last_pop - first_pop), 32'd15);
    chk("single_can_after", 32'(can), 32'd1);
    chk("single_valid_after", 32'(o_valid), 32'd0);

    // Backpressure 1,0,0,1.
    clr_stats();
    pulse(0, 1'b1);
    drain(200, 1'b1);
    chk("bp_beats", 32'(pop_cnt), 32'd16);

    // Ping-pong: pulses three cycles apart, no bubble at the slot switch.
    rdy = 1'b1;
    clr_stats();
    pulse('h1000, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    pulse('h2000, 1'b1);
    chk("pp_can_both_full", 32'(can), 32'd0);
    drain(200, 1'b0);
    chk("pp_beats", 32'(pop_cnt), 32'd32);
    chk("pp_contig", 32'(last_pop - first_pop), 32'd31);
    chk("pp_can_after", 32'(can), 32'd1);

    // Same-cycle free: C arrives with A's last handshake while both slots full.
    rdy = 1'b0;
    clr_stats();
    pulse('h3000, 1'b1);
    pulse('h4000, 1'b1);
    chk("sc_can_full", 32'(can), 32'd0);
    rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (o_valid && o_last) break;
      @(posedge clk);
      #1;
    end
    chk("sc_reach_last", 32'(o_last), 32'd1);
    chk("sc_can_no_anticipate", 32'(can), 32'd0);
    pulse('h5000, 1'b1);
    chk("sc_ovf", 32'(ovf), 32'd0);
    chk("sc_valid_b", 32'(o_valid), 32'd1);
    drain(200, 1'b0);
    chk("sc_beats", 32'(pop_cnt), 32'd48);

    // Overflow: table of per-cycle vectors with ready low.
    clr_stats();
    for (int i = 0; i < 5; i++) begin
      rdy = vecs[i].rdy;
      vld = vecs[i].vld;
      if (vecs[i].vld) c_in = gen(vecs[i].base);
      if (vecs[i].vld && vecs[i].acc) push_mat(vecs[i].base);
      @(posedge clk);
      #1;
      vld = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
      chk($sformatf("tbl%0d_can", i), 32'(can), 32'(vecs[i].e_can));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
    end
    drain(200, 1'b0);
    chk("ovf_beats", 32'(pop_cnt), 32'd32);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("ovf_valid_after", 32'(o_valid), 32'd0);

    // Reset mid-stream at beat 5.
    rdy = 1'b1;
    clr_stats();
    pulse('h6000, 1'b1);
    for (int n = 0; n < 20 && pop_cnt < 5; n++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_reached_beat5", 32'(pop_cnt), 32'd5);
    mon_en = 1'b0;
    q.delete();
    arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_can", 32'(can), 32'd1);
    chk("mid_rst_data", o_data, 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    mon_en = 1'b1;
    clr_stats();
    pulse('h7000, 1'b1);
    chk("mid_new_row", 32'(o_row), 32'd0);
    chk("mid_new_col", 32'(o_col), 32'd0);
    drain(100, 1'b0);
    chk("mid_new_beats", 32'(pop_cnt), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
